hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
Pipeline hazard and stall controller for the 5-stage MIPS core. Detects load-use hazards and multi-cycle multiply/divide hazards, and drives the PC/IF-ID write enables, the bubble select of the ID/EX stall mux (NOP insertion), and the IF/ID flush on taken branches. Sits beside the ID stage. Owns the mult/div busy counter and a stall-cycle performance counter.

Parameters:
MD_LATENCY, 32, cycles the mult/div unit stays busy after issue (legal range 1..63)
CNT_W, 6, width of the busy counter (must hold MD_LATENCY)
PERF_W, 16, width of the saturating stall-cycle counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
id_rs  input  5  rs field of the instruction in ID
id_rt  input  5  rt field of the instruction in ID
id_uses_rs  input  1  ID instruction reads rs
id_uses_rt  input  1  ID instruction reads rt
ex_mem_read  input  1  instruction in EX is a load
ex_rt  input  5  destination register of the load in EX
id_md_start  input  1  ID instruction is mult/multu/div/divu
id_md_read  input  1  ID instruction is mfhi/mflo
ex_branch_taken  input  1  branch/jump in EX resolved taken
pc_write  output  1  PC update enable
ifid_write  output  1  IF/ID register write enable
bubble_sel  output  1  1 = stall mux drives NOP into ID/EX
ifid_flush  output  1  clear IF/ID to NOP
md_busy  output  1  mult/div unit busy
md_count  output  CNT_W  remaining busy cycles
stall_cycles  output  PERF_W  saturating count of stalled cycles

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-high. While reset = 1: FSM = IDLE, md_count = 0, stall_cycles = 0, md_busy = 0. Outputs forced to pc_write = 1, ifid_write = 1, bubble_sel = 0, ifid_flush = 0. All hazard inputs are ignored.
- load_use (combinational): ex_mem_read & (ex_rt != 0) & ((id_uses_rs & id_rs == ex_rt) | (id_uses_rt & id_rt == ex_rt)). Register $0 never hazards.
- md_hazard (combinational): md_busy & (id_md_read | id_md_start).
- stall = (load_use | md_hazard) & ~ex_branch_taken.
- Output priority, highest first:
  - ex_branch_taken = 1: pc_write = 1, ifid_write = 1, ifid_flush = 1, bubble_sel = 1.
  - else if stall: pc_write = 0, ifid_write = 0, bubble_sel = 1, ifid_flush = 0.
  - else: pc_write = 1, ifid_write = 1, bubble_sel = 0, ifid_flush = 0.
  - All four outputs are combinational in the same cycle. Zero added latency.
- FSM states: IDLE, MD_BUSY. md_busy = (state == MD_BUSY).
  - IDLE -> MD_BUSY on a clock edge where id_md_start = 1, stall = 0 and ex_branch_taken = 0 (issue accepted). md_count loads MD_LATENCY.
  - MD_BUSY: md_count decrements by 1 each cycle. When md_count == 1, the next edge sets md_count = 0 and state = IDLE.
  - Busy timing: issue accepted at edge T gives md_busy high for exactly MD_LATENCY cycles. A dependent mfhi/mflo/mult waiting in ID proceeds in the first cycle md_busy = 0.
  - Issue is not accepted while busy: md_hazard stalls it. No back-to-back overlap.
  - A flush (ex_branch_taken) squashes the ID instruction. A pending id_md_start in that cycle does not issue.
  - A flush does not cancel a mult/div that is already busy.
- stall_cycles increments by 1 on each edge where stall = 1. It saturates at 2^PERF_W-1 and never wraps.
- Reset asserted mid-busy: returns immediately to IDLE with md_count = 0.

Test Plan:
- Load-use: ex_mem_read = 1, ex_rt = 8, id_rs = 8, id_uses_rs = 1 -> pc_write = 0, ifid_write = 0, bubble_sel = 1 for 1 cycle. Same stimulus with ex_rt = 0 -> no stall.
- Branch priority: load-use condition plus ex_branch_taken = 1 -> ifid_flush = 1, bubble_sel = 1, pc_write = 1. stall_cycles unchanged.
- Mult/div issue (MD_LATENCY = 4): id_md_start accepted at edge T -> md_busy = 1 with md_count 4, 3, 2, 1, then md_busy = 0.
  - mflo in ID from T+1 stalls exactly 4 cycles; stall_cycles = 4.
- Back-to-back mult during busy (MD_LATENCY = 4): second id_md_start is stalled until md_busy = 0, then issued. md_count reloads 4.
- Flushed issue: id_md_start = 1 with ex_branch_taken = 1 -> md_busy stays 0.
- Async reset: assert reset mid-busy with md_count = 2, between clock edges -> md_busy = 0, md_count = 0, stall_cycles = 0, pc_write = 1 immediately.
  - Saturation: force PERF_W = 4 with 20 continuous stall cycles -> stall_cycles = 15.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for the 5-stage MIPS pipeline. It detects load-use and
// mult/div hazards, drives the PC/IF-ID enables, the bubble mux and the branch flush.
module hazard_stall_ctrl #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 6,
    parameter int PERF_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rt,
    input  logic              id_md_start,
    input  logic              id_md_read,
    input  logic              ex_branch_taken,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              bubble_sel,
    output logic              ifid_flush,
    output logic              md_busy,
    output logic [CNT_W-1:0]  md_count,
    output logic [PERF_W-1:0] stall_cycles
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0]  MD_LAT_C  = CNT_W'(MD_LATENCY);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
    localparam logic [PERF_W-1:0] PERF_MAX  = {PERF_W{1'b1}};
    localparam logic [PERF_W-1:0] PERF_ONE  = PERF_W'(1);
    localparam logic [PERF_W-1:0] PERF_ZERO = PERF_W'(0);

    state_t            state_r;
    logic [CNT_W-1:0]  count_r;
    logic [PERF_W-1:0] perf_r;
    logic              load_use_s;
    logic              md_hazard_s;
    logic              stall_s;
    logic              issue_s;

    // True when an ID source operand reads the register written by the load in EX.
    function automatic logic src_match(input logic uses, input logic [4:0] src,
                                       input logic [4:0] dst);
        return uses & (src == dst);
    endfunction

    assign md_busy      = (state_r == MD_BUSY);
    assign md_count     = count_r;
    assign stall_cycles = perf_r;

    // Hazard detection and pipeline-control outputs, same cycle as the ID instruction.
    always_comb begin
        load_use_s  = ex_mem_read & (ex_rt != 5'd0) &
                      (src_match(id_uses_rs, id_rs, ex_rt) | src_match(id_uses_rt, id_rt, ex_rt));
        md_hazard_s = md_busy & (id_md_read | id_md_start);
        stall_s     = (load_use_s | md_hazard_s) & ~ex_branch_taken;
        issue_s     = id_md_start & ~stall_s & ~ex_branch_taken;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        bubble_sel  = 1'b0;
        ifid_flush  = 1'b0;
        if (reset) begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            bubble_sel = 1'b0;
            ifid_flush = 1'b0;
        end else if (ex_branch_taken) begin
            // The squashed ID instruction also becomes a bubble in ID/EX.
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            bubble_sel = 1'b1;
            ifid_flush = 1'b1;
        end else if (stall_s) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            bubble_sel = 1'b1;
            ifid_flush = 1'b0;
        end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            bubble_sel = 1'b0;
            ifid_flush = 1'b0;
        end
    end

    // Mult/div busy FSM with its countdown, plus the saturating stall counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            count_r <= CNT_ZERO;
            perf_r  <= PERF_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    if (issue_s) begin
                        state_r <= MD_BUSY;
                        count_r <= MD_LAT_C;
                    end else begin
                        state_r <= IDLE;
                        count_r <= CNT_ZERO;
                    end
                end
                MD_BUSY: begin
                    // A taken branch does not cancel an operation already in flight.
                    if (count_r <= CNT_ONE) begin
                        state_r <= IDLE;
                        count_r <= CNT_ZERO;
                    end else begin
                        state_r <= MD_BUSY;
                        count_r <= count_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    count_r <= CNT_ZERO;
                end
            endcase
            if (stall_s && (perf_r != PERF_MAX)) begin
                perf_r <= perf_r + PERF_ONE;
            end else begin
                perf_r <= perf_r;
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed literal cases plus randomized
// stimulus compared every cycle against a behavioural reference model.
module tb_hazard_stall_ctrl;

    localparam int LAT  = 4;
    localparam int PW   = 4;
    localparam int SMAX = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [4:0]    id_rs = 5'd0;
    logic [4:0]    id_rt = 5'd0;
    logic          id_uses_rs = 1'b0;
    logic          id_uses_rt = 1'b0;
    logic          ex_mem_read = 1'b0;
    logic [4:0]    ex_rt = 5'd0;
    logic          id_md_start = 1'b0;
    logic          id_md_read = 1'b0;
    logic          ex_branch_taken = 1'b0;
    logic          pc_write;
    logic          ifid_write;
    logic          bubble_sel;
    logic          ifid_flush;
    logic          md_busy;
    logic [5:0]    md_count;
    logic [PW-1:0] stall_cycles;

    int checks   = 0;
    int failures = 0;
    int m_rem    = 0;
    int m_stall  = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MD_LATENCY(LAT), .CNT_W(6), .PERF_W(PW)) dut (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
        .ex_rt(ex_rt), .id_md_start(id_md_start), .id_md_read(id_md_read),
        .ex_branch_taken(ex_branch_taken), .pc_write(pc_write), .ifid_write(ifid_write),
        .bubble_sel(bubble_sel), .ifid_flush(ifid_flush), .md_busy(md_busy),
        .md_count(md_count), .stall_cycles(stall_cycles)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; ex_rt = 5'd0; id_md_start = 1'b0; id_md_read = 1'b0;
        ex_branch_taken = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic at_sample();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic load_use_stim();
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    endtask

    // Reference model: busy = cycles left on the mult/div, stall count saturates.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                m_rem   = 0;
                m_stall = 0;
                chk("rst_pc_write", int'(pc_write), 1);
                chk("rst_ifid_write", int'(ifid_write), 1);
                chk("rst_bubble", int'(bubble_sel), 0);
                chk("rst_flush", int'(ifid_flush), 0);
                chk("rst_md_busy", int'(md_busy), 0);
                chk("rst_md_count", int'(md_count), 0);
                chk("rst_stall_cycles", int'(stall_cycles), 0);
            end else begin
                bit busy, lu, mh, st;
                busy = (m_rem > 0);
                lu = ex_mem_read && (ex_rt != 5'd0) &&
                     ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
                mh = busy && (id_md_read || id_md_start);
                st = (lu || mh) && !ex_branch_taken;
                chk("pc_write", int'(pc_write), int'(!st));
                chk("ifid_write", int'(ifid_write), int'(!st));
                chk("bubble_sel", int'(bubble_sel), int'(st || ex_branch_taken));
                chk("ifid_flush", int'(ifid_flush), int'(ex_branch_taken));
                chk("md_busy", int'(md_busy), int'(busy));
                chk("md_count", int'(md_count), m_rem);
                chk("stall_cycles", int'(stall_cycles), m_stall);
                if (busy) m_rem = m_rem - 1;
                else if (id_md_start && !st && !ex_branch_taken) m_rem = LAT;
                if (st && m_stall < SMAX) m_stall = m_stall + 1;
            end
        end
    end

    initial begin
        idle_inputs();
        at_sample();
        chk("reset_pc_write_lit", int'(pc_write), 1);
        chk("reset_busy_lit", int'(md_busy), 0);
        next_cycle();
        reset = 1'b0;

        // Load-use stall, $0 exemption, branch priority
        do_reset();
        load_use_stim();
        at_sample();
        chk("lu_pc_write", int'(pc_write), 0);
        chk("lu_ifid_write", int'(ifid_write), 0);
        chk("lu_bubble", int'(bubble_sel), 1);
        next_cycle();
        ex_rt = 5'd0; id_rs = 5'd0;
        at_sample();
        chk("r0_pc_write", int'(pc_write), 1);
        chk("r0_bubble", int'(bubble_sel), 0);
        chk("lu_stall_count", int'(stall_cycles), 1);
        next_cycle();
        load_use_stim();
        ex_branch_taken = 1'b1;
        at_sample();
        chk("br_flush", int'(ifid_flush), 1);
        chk("br_bubble", int'(bubble_sel), 1);
        chk("br_pc_write", int'(pc_write), 1);
        next_cycle();
        idle_inputs();
        at_sample();
        chk("br_stall_unchanged", int'(stall_cycles), 1);

        // Mult issue followed by dependent mflo
        do_reset();
        id_md_start = 1'b1;
        at_sample();
        chk("md_issue_not_busy", int'(md_busy), 0);
        next_cycle();
        id_md_start = 1'b0; id_md_read = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            at_sample();
            chk("md_busy_on", int'(md_busy), 1);
            chk("md_count_seq", int'(md_count), LAT - i);
            chk("mflo_stalled", int'(pc_write), 0);
            next_cycle();
        end
        at_sample();
        chk("md_busy_off", int'(md_busy), 0);
        chk("md_count_zero", int'(md_count), 0);
        chk("mflo_proceeds", int'(pc_write), 1);
        chk("mflo_stall_count", int'(stall_cycles), 4);
        next_cycle();
        idle_inputs();

        // Back-to-back mult is held until the unit frees up
        do_reset();
        id_md_start = 1'b1;
        next_cycle();
        for (int i = 0; i < LAT; i++) begin
            at_sample();
            chk("b2b_stalled", int'(pc_write), 0);
            next_cycle();
        end
        at_sample();
        chk("b2b_accepted", int'(pc_write), 1);
        next_cycle();
        id_md_start = 1'b0;
        at_sample();
        chk("b2b_busy", int'(md_busy), 1);
        chk("b2b_reload", int'(md_count), 4);

        // Flushed issue never starts the unit
        do_reset();
        id_md_start = 1'b1; ex_branch_taken = 1'b1;
        at_sample();
        chk("flush_issue_flush", int'(ifid_flush), 1);
        next_cycle();
        idle_inputs();
        at_sample();
        chk("flush_issue_busy", int'(md_busy), 0);
        chk("flush_issue_count", int'(md_count), 0);

        // Asynchronous reset in the middle of a busy period
        do_reset();
        id_md_start = 1'b1;
        next_cycle();
        id_md_start = 1'b0; id_md_read = 1'b1;
        next_cycle();
        next_cycle();
        at_sample();
        chk("pre_rst_count", int'(md_count), 2);
        chk("pre_rst_stalls", int'(stall_cycles), 2);
        chk("pre_rst_pc_write", int'(pc_write), 0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_busy", int'(md_busy), 0);
        chk("arst_count", int'(md_count), 0);
        chk("arst_stalls", int'(stall_cycles), 0);
        chk("arst_pc_write", int'(pc_write), 1);
        next_cycle();
        idle_inputs();
        next_cycle();
        reset = 1'b0;

        // Saturation of the 4-bit stall counter
        do_reset();
        load_use_stim();
        repeat (20) next_cycle();
        at_sample();
        chk("sat_stall_count", int'(stall_cycles), SMAX);
        next_cycle();
        idle_inputs();

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            reset           = ($urandom_range(0, 199) == 0);
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            id_uses_rs      = 1'($urandom_range(0, 1));
            id_uses_rt      = 1'($urandom_range(0, 1));
            ex_mem_read     = ($urandom_range(0, 2) == 0);
            ex_rt           = 5'($urandom_range(0, 3));
            id_md_start     = ($urandom_range(0, 3) == 0);
            id_md_read      = ($urandom_range(0, 3) == 0);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            next_cycle();
        end
        reset = 1'b0;
        idle_inputs();
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
